// File: rtl/reset_sequencer.sv
// Staged reset sequencer: qualifies the clock manager lock, then releases the
// peripheral/bus reset followed by the CPU reset, and handles warm resets and lock loss.
module reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_GAP          = 16,
  parameter int CNT_W              = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic locked,
  input  logic soft_reset_req,
  output logic periph_reset_,
  output logic cpu_reset_,
  output logic sys_ready,
  output logic soft_ack,
  output logic lock_lost
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    REL_PERIPH,
    RUN,
    SOFT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lock_meta, locked_s;
  logic             seen_run, seen_run_nxt;
  logic             periph_nxt, cpu_nxt, ready_nxt, ack_nxt, lost_nxt;

  // seen_run remembers that RUN was reached since reset, so later lock loss is flagged
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta     <= 1'b0;
      locked_s      <= 1'b0;
      state         <= WAIT_LOCK;
      cnt           <= '0;
      periph_reset_ <= 1'b0;
      cpu_reset_    <= 1'b0;
      sys_ready     <= 1'b0;
      soft_ack      <= 1'b0;
      lock_lost     <= 1'b0;
      seen_run      <= 1'b0;
    end else begin
      lock_meta     <= locked;
      locked_s      <= lock_meta;
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      periph_reset_ <= periph_nxt;
      cpu_reset_    <= cpu_nxt;
      sys_ready     <= ready_nxt;
      soft_ack      <= ack_nxt;
      lock_lost     <= lost_nxt;
      seen_run      <= seen_run_nxt;
    end
  end

  // Lock loss outranks any soft request, so it is resolved before the per-state logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    periph_nxt   = periph_reset_;
    cpu_nxt      = cpu_reset_;
    ready_nxt    = sys_ready;
    ack_nxt      = 1'b0;
    lost_nxt     = lock_lost;
    seen_run_nxt = seen_run;

    if (state != WAIT_LOCK && !locked_s) begin
      state_nxt  = WAIT_LOCK;
      cnt_nxt    = '0;
      periph_nxt = 1'b0;
      cpu_nxt    = 1'b0;
      ready_nxt  = 1'b0;
      if (seen_run) lost_nxt = 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          periph_nxt = 1'b0;
          cpu_nxt    = 1'b0;
          ready_nxt  = 1'b0;
          if (!locked_s) begin
            cnt_nxt = '0;
          end else if (cnt == LOCK_LAST) begin
            state_nxt  = REL_PERIPH;
            cnt_nxt    = '0;
            periph_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        REL_PERIPH: begin
          if (cnt == GAP_LAST) begin
            state_nxt    = RUN;
            cnt_nxt      = '0;
            cpu_nxt      = 1'b1;
            ready_nxt    = 1'b1;
            seen_run_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RUN: begin
          if (soft_reset_req) begin
            state_nxt  = SOFT;
            cnt_nxt    = '0;
            periph_nxt = 1'b0;
            cpu_nxt    = 1'b0;
            ready_nxt  = 1'b0;
            ack_nxt    = 1'b1;
          end
        end
        SOFT: begin
          if (cnt == GAP_LAST) begin
            state_nxt  = REL_PERIPH;
            cnt_nxt    = '0;
            periph_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule
